// File: rtl/shifter_pipelined.sv
// Pipelined barrel shifter: one registered stage per shift-amount bit, valid/ready handshake.
// Define SHIFTER_PIPELINED_ROTATE_EN to build rotate-left for mode 11 (otherwise mode 11 is SLL).
module shifter_pipelined #(
  parameter int unsigned N = 32,
  parameter int unsigned S = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in,
  input  logic [S-1:0] shamt,
  input  logic [1:0]   mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out
);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  logic [N-1:0] data_q   [S];
  logic         valid_q  [S];
  logic [1:0]   mode_q   [S];
  logic [S-1:0] sh_q     [S];

  logic [N-1:0] data_nxt [S];
  logic         valid_nxt[S];
  logic [1:0]   mode_nxt [S];
  logic [S-1:0] sh_nxt   [S];

  logic stall;

  // One conditional fixed-distance shift; SRA keeps the MSB, so the original sign propagates.
  function automatic logic [N-1:0] stage_op(input logic [N-1:0] d, input logic en,
                                            input logic [1:0] md, input int unsigned amt);
    logic [N-1:0] r;
    r = d;
    if (en) begin
      case (md)
        MODE_SRL: r = d >> amt;
        MODE_SRA: r = N'($signed(d) >>> amt);
`ifdef SHIFTER_PIPELINED_ROTATE_EN
        MODE_ROL: r = (d << amt) | (d >> (N - amt));
`endif
        default:  r = d << amt;
      endcase
    end
    return r;
  endfunction

  assign stall     = valid_q[S-1] && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = valid_q[S-1];
  assign out       = data_q[S-1];

  // Next-state for every stage; stage k consumes the low bit of the shamt it carries.
  always_comb begin
    for (int k = 0; k < S; k++) begin
      data_nxt[k]  = '0;
      valid_nxt[k] = 1'b0;
      mode_nxt[k]  = MODE_SLL;
      sh_nxt[k]    = '0;
    end
    data_nxt[0]  = stage_op(in, shamt[0], mode, 32'd1);
    valid_nxt[0] = in_valid;
    mode_nxt[0]  = mode;
    sh_nxt[0]    = shamt >> 1;
    for (int k = 1; k < S; k++) begin
      data_nxt[k]  = stage_op(data_q[k-1], sh_q[k-1][0], mode_q[k-1], 32'd1 << k);
      valid_nxt[k] = valid_q[k-1];
      mode_nxt[k]  = mode_q[k-1];
      sh_nxt[k]    = sh_q[k-1] >> 1;
    end
  end

  // Whole pipe freezes on stall; bubbles advance like data otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < S; k++) begin
        data_q[k]  <= '0;
        valid_q[k] <= 1'b0;
        mode_q[k]  <= MODE_SLL;
        sh_q[k]    <= '0;
      end
    end else if (!stall) begin
      for (int k = 0; k < S; k++) begin
        data_q[k]  <= data_nxt[k];
        valid_q[k] <= valid_nxt[k];
        mode_q[k]  <= mode_nxt[k];
        sh_q[k]    <= sh_nxt[k];
      end
    end
  end

endmodule

// File: tb/tb_shifter_pipelined.sv
// Scoreboard bench for shifter_pipelined (N=32): latency, modes, throughput, stall, reset flush, rotate.
module tb_shifter_pipelined;
  localparam int unsigned N = 32;
  localparam int unsigned S = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in;
  logic [S-1:0] shamt;
  logic [1:0]   mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] got_q[$];
  int           got_cyc[$];

  shifter_pipelined #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(in),
    .shamt(shamt), .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] ref_op(input logic [N-1:0] a, input logic [S-1:0] sh,
                                          input logic [1:0] md);
    logic [N-1:0] r;
    r = '0;
    case (md)
      2'b01: r = a >> sh;
      2'b10: begin
        for (int i = 0; i < N; i++)
          r[i] = (i + int'(sh) < N) ? a[i + int'(sh)] : a[N-1];
      end
`ifdef SHIFTER_PIPELINED_ROTATE_EN
      2'b11: begin
        for (int i = 0; i < N; i++) r[(i + int'(sh)) % N] = a[i];
      end
`endif
      default: r = a << sh;
    endcase
    return r;
  endfunction

  // Scoreboard: push on accepted input, pop and compare on output transfer.
  always @(negedge clk) begin
    logic [N-1:0] e;
    cyc++;
    if (rst !== 1'b1) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got out=%h with no pending operation", out);
        end else begin
          e = exp_q.pop_front();
          if (out !== e) begin
            errors++;
            $display("FAIL sb_data: got %h expected %h", out, e);
          end
        end
        got_q.push_back(out);
        got_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) exp_q.push_back(ref_op(in, shamt, mode));
    end
  end

  task automatic drive(input logic v, input logic [N-1:0] a, input logic [S-1:0] sh,
                       input logic [1:0] md);
    in_valid = v;
    in       = a;
    shamt    = sh;
    mode     = md;
  endtask

  // Sends one operation and waits (bounded) for its result.
  task automatic run_op(input logic [N-1:0] a, input logic [S-1:0] sh, input logic [1:0] md,
                        output logic [N-1:0] res, output bit ok);
    int base;
    base = got_q.size();
    ok   = 1'b0;
    res  = '0;
    drive(1'b1, a, sh, md);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1;
      if (got_q.size() > base) begin
        ok  = 1'b1;
        res = got_q[base];
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (out !== '0) begin errors++; $display("FAIL reset_out: got %h expected 0", out); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_latency();
    int seen;
    seen = 0;
    drive(1'b1, 32'h0000_0001, 5'd31, 2'b00);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1 && seen == 0) seen = i;
    end
    checks++;
    if (seen != 5) begin errors++; $display("FAIL latency: out_valid after %0d cycles expected 5", seen); end
    checks++;
    if (out !== 32'h8000_0000) begin errors++; $display("FAIL sll31: got %h expected 80000000", out); end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_sra_srl();
    logic [N-1:0] r;
    bit ok;
    run_op(32'h8000_00F0, 5'd4, 2'b10, r, ok);
    checks++;
    if (!ok || r !== 32'hF800_000F) begin errors++; $display("FAIL sra: got %h ok=%0d expected f800000f", r, ok); end
    run_op(32'h8000_00F0, 5'd4, 2'b01, r, ok);
    checks++;
    if (!ok || r !== 32'h0800_000F) begin errors++; $display("FAIL srl: got %h ok=%0d expected 0800000f", r, ok); end
  endtask

  task automatic test_shamt0();
    logic [N-1:0] r;
    bit ok;
    for (int m = 0; m < 4; m++) begin
      run_op(32'hA5C3_0F81, 5'd0, 2'(m), r, ok);
      checks++;
      if (!ok || r !== 32'hA5C3_0F81) begin errors++; $display("FAIL shamt0_mode%0d: got %h expected a5c30f81", m, r); end
    end
  endtask

  task automatic test_rotate();
    logic [N-1:0] r;
    logic [N-1:0] want;
    bit ok;
`ifdef SHIFTER_PIPELINED_ROTATE_EN
    want = 32'h0000_0003;
`else
    want = 32'h0000_0002;
`endif
    run_op(32'h8000_0001, 5'd1, 2'b11, r, ok);
    checks++;
    if (!ok || r !== want) begin errors++; $display("FAIL rotate: got %h expected %h", r, want); end
  endtask

  task automatic test_back_to_back();
    int base;
    int bad;
    base = got_q.size();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, $urandom, S'($urandom_range(0, N-1)), 2'($urandom_range(0, 3)));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 40 && got_q.size() < base + 32; i++) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != base + 32) begin
      errors++;
      $display("FAIL b2b_count: got %0d results expected 32", got_q.size() - base);
    end else begin
      bad = 0;
      for (int i = 1; i < 32; i++)
        if (got_cyc[base + i] != got_cyc[base] + i) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL b2b_consecutive: %0d gaps expected 0", bad); end
    end
  endtask

  task automatic test_stall();
    int base;
    logic [N-1:0] held;
    bit hit;
    base = got_q.size();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1111_0000 + 32'(i), S'(i + 3), 2'(i));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if (out_valid === 1'b1) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL stall_wait: out_valid never rose"); end
    out_ready = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 5'd7, 2'b01);
    held = out;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: out=%h v=%b rdy=%b expected out=%h v=1 rdy=0",
                 i, out, out_valid, in_ready, held);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() - base != 5 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_count: got %0d results pending %0d expected 5 and 0",
               got_q.size() - base, exp_q.size());
    end
  endtask

  task automatic test_reset_flush();
    int base;
    base = got_q.size();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hF0F0_0000 + 32'(i), S'(i + 1), 2'b00);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    drive(1'b1, 32'h0BAD_0BAD, 5'd2, 2'b00);
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out !== '0) begin
      errors++;
      $display("FAIL flush_out: v=%b out=%h expected v=0 out=0", out_valid, out);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != base) begin
      errors++;
      $display("FAIL flush_leak: %0d results appeared expected 0", got_q.size() - base);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_sra_srl();
    test_shamt0();
    test_rotate();
    test_back_to_back();
    test_stall();
    test_reset_flush();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
